// File: rtl/spm_test_loader_pkg.sv
// Shared SPM test-port constants and address helper for the test loader.
package spm_test_loader_pkg;

  // SPM word address and data widths
  localparam int unsigned SPM_ADDR_W = 30;
  localparam int unsigned SPM_DATA_W = 32;

  // Test-port read/write direction encodings
  localparam logic SPM_READ  = 1'b1;
  localparam logic SPM_WRITE = 1'b0;

  // Word address offset, wrapping modulo 2^SPM_ADDR_W
  function automatic logic [SPM_ADDR_W-1:0] spm_addr_add(
    input logic [SPM_ADDR_W-1:0] base,
    input logic [SPM_ADDR_W-1:0] off
  );
    return base + off;
  endfunction

endpackage : spm_test_loader_pkg

// File: rtl/spm_test_loader.sv
// Streams a block of words into the SPM test port, optionally reads them back
// to confirm the sum, then releases the CPU.
module spm_test_loader
  import spm_test_loader_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter bit          VERIFY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SPM_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]      word_count,
  input  logic                  s_valid,
  input  logic [SPM_DATA_W-1:0] s_data,
  output logic                  s_ready,
  output logic [SPM_ADDR_W-1:0] test_spm_addr,
  output logic                  test_spm_as_,
  output logic                  test_spm_rw,
  output logic [SPM_DATA_W-1:0] test_spm_wr_data,
  input  logic [SPM_DATA_W-1:0] test_spm_rd_data,
  output logic                  cpu_en,
  output logic                  busy,
  output logic                  error,
  output logic [SPM_DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_VWAIT  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [SPM_ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]      rb_cnt_q, rb_cnt_d;
  logic [SPM_DATA_W-1:0] checksum_q, checksum_d;
  logic [SPM_DATA_W-1:0] rb_sum_q, rb_sum_d;
  logic                  rd_cap_q, rd_cap_d;
  logic                  s_ready_q, s_ready_d;
  logic                  as_q, as_d;
  logic                  rw_q, rw_d;
  logic [SPM_ADDR_W-1:0] addr_q, addr_d;
  logic [SPM_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  cpu_en_q, cpu_en_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  // State and registered outputs; reset also kills any strobe in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      rb_cnt_q   <= '0;
      checksum_q <= '0;
      rb_sum_q   <= '0;
      rd_cap_q   <= 1'b0;
      s_ready_q  <= 1'b0;
      as_q       <= 1'b1;
      rw_q       <= SPM_READ;
      addr_q     <= '0;
      wr_data_q  <= '0;
      cpu_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      rb_cnt_q   <= rb_cnt_d;
      checksum_q <= checksum_d;
      rb_sum_q   <= rb_sum_d;
      rd_cap_q   <= rd_cap_d;
      s_ready_q  <= s_ready_d;
      as_q       <= as_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      cpu_en_q   <= cpu_en_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
    end
  end

  // Next-state, strobe generation, checksum and readback accumulation
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    idx_d      = idx_q;
    rd_idx_d   = rd_idx_q;
    rb_cnt_d   = rb_cnt_q;
    checksum_d = checksum_q;
    rb_sum_d   = rb_sum_q;
    rd_cap_d   = 1'b0;
    as_d       = 1'b1;
    rw_d       = SPM_READ;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          base_d     = base_addr;
          count_d    = word_count;
          idx_d      = '0;
          rd_idx_d   = '0;
          rb_cnt_d   = '0;
          checksum_d = '0;
          rb_sum_d   = '0;
          state_d    = (word_count == '0) ? ST_DONE : ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (s_valid && s_ready_q) begin
          as_d       = 1'b0;
          rw_d       = SPM_WRITE;
          addr_d     = spm_addr_add(base_q, SPM_ADDR_W'(idx_q));
          wr_data_d  = s_data;
          checksum_d = checksum_q + s_data;
          idx_d      = CNT_W'(idx_q + CNT_W'(1));
          // Final write strobe is registered on this same edge
          if (idx_d == count_q) begin
            state_d = VERIFY ? ST_VERIFY : ST_DONE;
          end
        end
      end

      ST_VERIFY: begin
        as_d     = 1'b0;
        rw_d     = SPM_READ;
        addr_d   = spm_addr_add(base_q, SPM_ADDR_W'(rd_idx_q));
        rd_idx_d = CNT_W'(rd_idx_q + CNT_W'(1));
        if (rd_idx_d == count_q) begin
          state_d = ST_VWAIT;
        end
      end

      default: ;
    endcase

    // Read data lands the cycle after its strobe is on the port
    if ((state_q == ST_VERIFY || state_q == ST_VWAIT) && !as_q && rw_q == SPM_READ) begin
      rd_cap_d = 1'b1;
    end

    if (rd_cap_q && (state_q == ST_VERIFY || state_q == ST_VWAIT)) begin
      rb_sum_d = rb_sum_q + test_spm_rd_data;
      rb_cnt_d = CNT_W'(rb_cnt_q + CNT_W'(1));
      if (state_q == ST_VWAIT && rb_cnt_d == count_q) begin
        state_d = (rb_sum_d == checksum_q) ? ST_DONE : ST_ERROR;
      end
    end

    s_ready_d = (state_d == ST_LOAD) && (idx_d < count_d);
    cpu_en_d  = (state_d == ST_DONE);
    busy_d    = (state_d == ST_LOAD) || (state_d == ST_VERIFY) || (state_d == ST_VWAIT);
    error_d   = (state_d == ST_ERROR);
  end

  assign s_ready          = s_ready_q;
  assign test_spm_addr    = addr_q;
  assign test_spm_as_     = as_q;
  assign test_spm_rw      = rw_q;
  assign test_spm_wr_data = wr_data_q;
  assign cpu_en           = cpu_en_q;
  assign busy             = busy_q;
  assign error            = error_q;
  assign checksum         = checksum_q;

endmodule : spm_test_loader

// File: tb/tb_spm_test_loader.sv
// Directed bench for spm_test_loader with a one-cycle-latency SPM model.
module tb_spm_test_loader;
  import spm_test_loader_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic                  clk;
  logic                  reset;
  logic                  start;
  logic [SPM_ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]      word_count;
  logic                  s_valid;
  logic [31:0]           s_data;
  logic                  s_ready;
  logic [SPM_ADDR_W-1:0] test_spm_addr;
  logic                  test_spm_as_;
  logic                  test_spm_rw;
  logic [31:0]           test_spm_wr_data;
  logic [31:0]           test_spm_rd_data;
  logic                  cpu_en;
  logic                  busy;
  logic                  error;
  logic [31:0]           checksum;

  int n_checks = 0;
  int n_fail   = 0;

  // SPM model and activity logs
  logic [31:0]           mem [0:1023];
  logic                  corrupt_en = 1'b0;
  logic [SPM_ADDR_W-1:0] corrupt_addr = '0;
  int                    cyc = 0;
  int                    strobe_cnt = 0;
  int                    hs_cyc[$];
  int                    wr_cyc[$];
  logic [SPM_ADDR_W-1:0] wr_addr[$];

  spm_test_loader #(.CNT_W(CNT_W), .VERIFY(1'b1)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .base_addr        (base_addr),
    .word_count       (word_count),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .test_spm_addr    (test_spm_addr),
    .test_spm_as_     (test_spm_as_),
    .test_spm_rw      (test_spm_rw),
    .test_spm_wr_data (test_spm_wr_data),
    .test_spm_rd_data (test_spm_rd_data),
    .cpu_en           (cpu_en),
    .busy             (busy),
    .error            (error),
    .checksum         (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPM behaviour: write on strobe, read data valid the following cycle
  always @(posedge clk) begin
    if (s_valid && s_ready) hs_cyc.push_back(cyc);
    if (!test_spm_as_) begin
      strobe_cnt <= strobe_cnt + 1;
      if (test_spm_rw == SPM_WRITE) begin
        mem[test_spm_addr[9:0]] <= test_spm_wr_data;
        wr_cyc.push_back(cyc);
        wr_addr.push_back(test_spm_addr);
      end else begin
        test_spm_rd_data <= (corrupt_en && test_spm_addr == corrupt_addr) ? 32'h0
                                                                          : mem[test_spm_addr[9:0]];
      end
    end
    cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [SPM_ADDR_W-1:0] b, input logic [CNT_W-1:0] c);
    start      = 1'b1;
    base_addr  = b;
    word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int tries;
    tries   = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && tries < 50) begin
      tick();
      tries++;
    end
    if (!s_ready) check("ready_timeout", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_end();
    int tries;
    tries = 0;
    while (!cpu_en && !error && tries < 200) begin
      tick();
      tries++;
    end
  endtask

  task automatic clear_logs();
    hs_cyc.delete();
    wr_cyc.delete();
    wr_addr.delete();
  endtask

  initial begin
    int tries;
    int strobes_before;
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    repeat (3) tick();

    // Reset state
    check("rst_as_",      32'(test_spm_as_),  32'd1);
    check("rst_rw",       32'(test_spm_rw),   32'(SPM_READ));
    check("rst_addr",     32'(test_spm_addr), 32'd0);
    check("rst_wr_data",  test_spm_wr_data,   32'd0);
    check("rst_s_ready",  32'(s_ready),       32'd0);
    check("rst_cpu_en",   32'(cpu_en),        32'd0);
    check("rst_busy",     32'(busy),          32'd0);
    check("rst_error",    32'(error),         32'd0);
    check("rst_checksum", checksum,           32'd0);
    reset = 1'b0;
    tick();

    // Basic load of 1,2,3,4 at 0x100 with matching readback
    clear_logs();
    start_load(30'h100, 16'd4);
    check("t1_busy",    32'(busy),    32'd1);
    check("t1_s_ready", 32'(s_ready), 32'd1);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    send_word(32'd4);
    wait_end();
    check("t1_cpu_en",   32'(cpu_en),   32'd1);
    check("t1_error",    32'(error),    32'd0);
    check("t1_busy_end", 32'(busy),     32'd0);
    check("t1_checksum", checksum,      32'd10);
    check("t1_nwr",      32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr.size()) check($sformatf("t1_wr_addr%0d", i), 32'(wr_addr[i]), 32'h100 + 32'(i));
      if (i < wr_cyc.size() && i < hs_cyc.size())
        check($sformatf("t1_wr_lat%0d", i), 32'(wr_cyc[i] - hs_cyc[i]), 32'd1);
    end
    check("t1_mem102", mem[10'h102], 32'd3);

    // Same load with readback corrupted at 0x102
    clear_logs();
    corrupt_en   = 1'b1;
    corrupt_addr = 30'h102;
    start_load(30'h100, 16'd4);
    check("t2_cpu_en_drop", 32'(cpu_en), 32'd0);
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    send_word(32'd4);
    wait_end();
    check("t2_error",    32'(error),  32'd1);
    check("t2_cpu_en",   32'(cpu_en), 32'd0);
    check("t2_busy",     32'(busy),   32'd0);
    check("t2_checksum", checksum,    32'd10);
    corrupt_en = 1'b0;

    // Zero-length load goes straight to DONE without strobing
    strobes_before = strobe_cnt;
    start_load(30'h55, 16'd0);
    check("t3_cpu_en",   32'(cpu_en), 32'd1);
    check("t3_busy",     32'(busy),   32'd0);
    check("t3_error",    32'(error),  32'd0);
    check("t3_checksum", checksum,    32'd0);
    repeat (4) tick();
    check("t3_no_strobe", 32'(strobe_cnt - strobes_before), 32'd0);

    // Address wrap past the top of the SPM
    clear_logs();
    start_load(30'h3FFF_FFFE, 16'd3);
    send_word(32'h10);
    send_word(32'h20);
    send_word(32'hFFFF_FFFF);
    wait_end();
    check("t4_nwr",      32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() > 0) check("t4_wr_addr0", 32'(wr_addr[0]), 32'h3FFF_FFFE);
    if (wr_addr.size() > 1) check("t4_wr_addr1", 32'(wr_addr[1]), 32'h3FFF_FFFF);
    if (wr_addr.size() > 2) check("t4_wr_addr2", 32'(wr_addr[2]), 32'h0);
    check("t4_checksum", checksum,     32'h2F);
    check("t4_cpu_en",   32'(cpu_en),  32'd1);

    // Gapped stream with an ignored start mid-load
    clear_logs();
    start_load(30'h200, 16'd3);
    send_word(32'd5);
    start      = 1'b1;
    base_addr  = 30'h0;
    word_count = 16'd9;
    tick();
    start = 1'b0;
    check("t5_busy_after_start", 32'(busy), 32'd1);
    check("t5_checksum_mid",     checksum,  32'd5);
    send_word(32'd6);
    tick();
    send_word(32'd7);
    wait_end();
    check("t5_nhs", 32'(hs_cyc.size()),  32'd3);
    check("t5_nwr", 32'(wr_addr.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr.size()) check($sformatf("t5_wr_addr%0d", i), 32'(wr_addr[i]), 32'h200 + 32'(i));
      if (i < wr_cyc.size() && i < hs_cyc.size())
        check($sformatf("t5_wr_lat%0d", i), 32'(wr_cyc[i] - hs_cyc[i]), 32'd1);
    end
    check("t5_checksum", checksum,    32'd18);
    check("t5_cpu_en",   32'(cpu_en), 32'd1);

    // Reset while reads are being issued
    start_load(30'h300, 16'd4);
    send_word(32'hA);
    send_word(32'hB);
    send_word(32'hC);
    send_word(32'hD);
    tries = 0;
    while (!(!test_spm_as_ && test_spm_rw == SPM_READ) && tries < 50) begin
      tick();
      tries++;
    end
    check("t6_read_seen", 32'(test_spm_rw == SPM_READ && !test_spm_as_), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_as_",      32'(test_spm_as_), 32'd1);
    check("t6_cpu_en",   32'(cpu_en),       32'd0);
    check("t6_busy",     32'(busy),         32'd0);
    check("t6_checksum", checksum,          32'd0);
    check("t6_s_ready",  32'(s_ready),      32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    check("t6_idle_as_",  32'(test_spm_as_), 32'd1);
    check("t6_idle_busy", 32'(busy),         32'd0);
    check("t6_idle_cpu",  32'(cpu_en),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spm_test_loader
